// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and stall controller for a 5-stage MIPS pipeline.
//
// Purpose:
//   - Forwarding selects for the X-stage ALU operands, D-stage branch
//     comparator and M-stage store data.
//   - Load-use and branch-operand stalls, redirect flushes.
//   - Sequencing of a variable-latency data memory (req/ack). The pipeline
//     is frozen while an access is outstanding. After MEM_TIMEOUT frozen
//     cycles the access is force-released and a sticky timeout flag is set.
//   - Saturating stall / flush performance counters.
//
// Ports:
//   clk, reset (async, active-low)
//   rs_d, rt_d, rs_x, rt_x, rt_m         source register ids per stage
//   write_reg_x/m/w, reg_write_x/m/w     destination ids / write enables
//   mem_to_reg_x/m, dmem_write_m         load in X/M, store in M
//   branch_d, jump_d, pc_src_d           control-flow info from D
//   dmem_ack                             memory completes access this cycle
//   cnt_clear                            sync clear of counters + timeout flag
//   stall_f/d/x/m, flush_d/x/w           pipeline register controls
//   fwd_a_d, fwd_b_d, fwd_a_x, fwd_b_x   operand forwarding selects
//   forward_w_m                          store data from result_w
//   dmem_req, mem_timeout                memory request, sticky timeout
//   stall_count, flush_count             saturating performance counters
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [4:0]       rs_x,
  input  logic [4:0]       rt_x,
  input  logic [4:0]       rt_m,
  input  logic [4:0]       write_reg_x,
  input  logic [4:0]       write_reg_m,
  input  logic [4:0]       write_reg_w,
  input  logic             reg_write_x,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             mem_to_reg_x,
  input  logic             mem_to_reg_m,
  input  logic             dmem_write_m,
  input  logic             branch_d,
  input  logic             jump_d,
  input  logic             pc_src_d,
  input  logic             dmem_ack,
  input  logic             cnt_clear,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_x,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_x,
  output logic             flush_w,
  output logic             fwd_a_d,
  output logic             fwd_b_d,
  output logic [1:0]       fwd_a_x,
  output logic [1:0]       fwd_b_x,
  output logic             forward_w_m,
  output logic             dmem_req,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] TMO_LAST = WC_W'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, MEM_WAIT = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_count_q, flush_count_q;
  logic              mem_timeout_q;

  logic mem_op_s, tmo_hit_s, freeze_s, tmo_set_s;
  logic lwstall_s, brstall_s;

  // Register match helper: register 0 is hard-wired and never a hazard.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  // Forwarding selects and hazard detection (pure combinational).
  always_comb begin
    if (reg_write_m && reg_match(write_reg_m, rs_x))      fwd_a_x = 2'b10;
    else if (reg_write_w && reg_match(write_reg_w, rs_x)) fwd_a_x = 2'b01;
    else                                                  fwd_a_x = 2'b00;

    if (reg_write_m && reg_match(write_reg_m, rt_x))      fwd_b_x = 2'b10;
    else if (reg_write_w && reg_match(write_reg_w, rt_x)) fwd_b_x = 2'b01;
    else                                                  fwd_b_x = 2'b00;

    fwd_a_d     = reg_write_m && reg_match(write_reg_m, rs_d);
    fwd_b_d     = reg_write_m && reg_match(write_reg_m, rt_d);
    forward_w_m = dmem_write_m && reg_write_w && reg_match(write_reg_w, rt_m);

    lwstall_s = mem_to_reg_x && (reg_match(rt_x, rs_d) || reg_match(rt_x, rt_d));
    brstall_s = branch_d &&
                ((reg_write_x  && (reg_match(write_reg_x, rs_d) || reg_match(write_reg_x, rt_d))) ||
                 (mem_to_reg_m && (reg_match(write_reg_m, rs_d) || reg_match(write_reg_m, rt_d))));
  end

  // FSM state register: outstanding-access tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // FSM next-state logic. An ack always wins over the timeout; an access
  // that disappears from M (mem_op drops) simply abandons the wait.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    tmo_set_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op_s && !dmem_ack) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end else begin
          state_d    = IDLE;
        end
      end
      MEM_WAIT: begin
        if (!mem_op_s || dmem_ack) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (tmo_hit_s) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
          tmo_set_s  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // FSM outputs: memory request, freeze and the resulting stall/flush set.
  always_comb begin
    mem_op_s  = mem_to_reg_m || dmem_write_m;
    dmem_req  = mem_op_s;
    tmo_hit_s = (state_q == MEM_WAIT) && (wait_cnt_q == TMO_LAST);
    freeze_s  = mem_op_s && !dmem_ack && !tmo_hit_s;
    if (freeze_s) begin
      // Freeze overrides every other hazard: nothing moves, W gets bubbles.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_x = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
      flush_x = 1'b0;
      flush_d = 1'b0;
    end else begin
      stall_f = lwstall_s || brstall_s;
      stall_d = lwstall_s || brstall_s;
      flush_x = lwstall_s || brstall_s;
      stall_x = 1'b0;
      stall_m = 1'b0;
      flush_w = 1'b0;
      flush_d = (pc_src_d || jump_d) && !(lwstall_s || brstall_s);
    end
  end

  // Performance counters and sticky timeout flag; clear wins over update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
      mem_timeout_q <= 1'b0;
    end else if (cnt_clear) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      if (stall_d && (stall_count_q != {CNT_W{1'b1}})) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end else begin
        stall_count_q <= stall_count_q;
      end
      if ((flush_x || flush_d) && (flush_count_q != {CNT_W{1'b1}})) begin
        flush_count_q <= flush_count_q + CNT_W'(1);
      end else begin
        flush_count_q <= flush_count_q;
      end
      if (tmo_set_s) begin
        mem_timeout_q <= 1'b1;
      end else begin
        mem_timeout_q <= mem_timeout_q;
      end
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl. The stimulus process drives inputs just
// after each rising edge, evaluates a behavioural model, and pushes the
// expected outputs; a monitor pops and compares on every falling edge.
module tb_hazard_ctrl;

  localparam int MT    = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b1;
  logic reset;
  logic [4:0] rs_d, rt_d, rs_x, rt_x, rt_m, write_reg_x, write_reg_m, write_reg_w;
  logic reg_write_x, reg_write_m, reg_write_w, mem_to_reg_x, mem_to_reg_m, dmem_write_m;
  logic branch_d, jump_d, pc_src_d, dmem_ack, cnt_clear;
  logic stall_f, stall_d, stall_x, stall_m, flush_d, flush_x, flush_w;
  logic fwd_a_d, fwd_b_d, forward_w_m, dmem_req, mem_timeout;
  logic [1:0] fwd_a_x, fwd_b_x;
  logic [CW-1:0] stall_count, flush_count;

  hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .rs_x(rs_x), .rt_x(rt_x), .rt_m(rt_m),
    .write_reg_x(write_reg_x), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_x(reg_write_x), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_x(mem_to_reg_x), .mem_to_reg_m(mem_to_reg_m), .dmem_write_m(dmem_write_m),
    .branch_d(branch_d), .jump_d(jump_d), .pc_src_d(pc_src_d),
    .dmem_ack(dmem_ack), .cnt_clear(cnt_clear),
    .stall_f(stall_f), .stall_d(stall_d), .stall_x(stall_x), .stall_m(stall_m),
    .flush_d(flush_d), .flush_x(flush_x), .flush_w(flush_w),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_x(fwd_a_x), .fwd_b_x(fwd_b_x),
    .forward_w_m(forward_w_m), .dmem_req(dmem_req), .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       stall_f, stall_d, stall_x, stall_m, flush_d, flush_x, flush_w;
    logic       fwd_a_d, fwd_b_d, forward_w_m, dmem_req, mem_timeout;
    logic [1:0] fwd_a_x, fwd_b_x;
    int         stall_count, flush_count;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state: cycles already spent frozen on the current access, counters.
  int frozen = 0;
  int st_cnt = 0;
  int fl_cnt = 0;
  bit tmo    = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [1:0] fsel(input logic [4:0] src);
    if (reg_write_m && hit(write_reg_m, src)) return 2'd2;
    if (reg_write_w && hit(write_reg_w, src)) return 2'd1;
    return 2'd0;
  endfunction

  // One cycle: compute expectations from current inputs, queue them, advance
  // the model across the coming edge, then move to just after that edge.
  task automatic step();
    exp_t e;
    bit mem_op, lw, br, fr, tmo_evt, hz;
    if (!reset) begin
      frozen = 0; st_cnt = 0; fl_cnt = 0; tmo = 1'b0;
    end
    mem_op  = mem_to_reg_m | dmem_write_m;
    fr      = mem_op && !dmem_ack && (frozen < MT);
    tmo_evt = mem_op && !dmem_ack && (frozen >= MT);
    lw = mem_to_reg_x && (hit(rt_x, rs_d) || hit(rt_x, rt_d));
    br = branch_d && ((reg_write_x && (hit(write_reg_x, rs_d) || hit(write_reg_x, rt_d))) ||
                      (mem_to_reg_m && (hit(write_reg_m, rs_d) || hit(write_reg_m, rt_d))));
    hz = lw || br;
    e.stall_f = fr || hz;
    e.stall_d = fr || hz;
    e.stall_x = fr;
    e.stall_m = fr;
    e.flush_w = fr;
    e.flush_x = !fr && hz;
    e.flush_d = !fr && !hz && (pc_src_d || jump_d);
    e.fwd_a_x = fsel(rs_x);
    e.fwd_b_x = fsel(rt_x);
    e.fwd_a_d = reg_write_m && hit(write_reg_m, rs_d);
    e.fwd_b_d = reg_write_m && hit(write_reg_m, rt_d);
    e.forward_w_m = dmem_write_m && reg_write_w && hit(write_reg_w, rt_m);
    e.dmem_req = mem_op;
    e.mem_timeout = tmo;
    e.stall_count = st_cnt;
    e.flush_count = fl_cnt;
    sb.push_back(e);
    if (reset) begin
      if (cnt_clear) begin
        st_cnt = 0; fl_cnt = 0; tmo = 1'b0;
      end else begin
        if (e.stall_d && st_cnt < CMAX) st_cnt++;
        if ((e.flush_x || e.flush_d) && fl_cnt < CMAX) fl_cnt++;
        if (tmo_evt) tmo = 1'b1;
      end
      frozen = fr ? frozen + 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b1;
    {rs_d, rt_d, rs_x, rt_x, rt_m} = 25'd0;
    {write_reg_x, write_reg_m, write_reg_w} = 15'd0;
    {reg_write_x, reg_write_m, reg_write_w} = 3'd0;
    {mem_to_reg_x, mem_to_reg_m, dmem_write_m} = 3'd0;
    {branch_d, jump_d, pc_src_d} = 3'd0;
    dmem_ack = 1'b0;
    cnt_clear = 1'b0;
  endtask

  // Monitor: every falling edge the DUT presents a full output set.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("stall_f", 32'(stall_f), 32'(mon_e.stall_f));
      chk("stall_d", 32'(stall_d), 32'(mon_e.stall_d));
      chk("stall_x", 32'(stall_x), 32'(mon_e.stall_x));
      chk("stall_m", 32'(stall_m), 32'(mon_e.stall_m));
      chk("flush_d", 32'(flush_d), 32'(mon_e.flush_d));
      chk("flush_x", 32'(flush_x), 32'(mon_e.flush_x));
      chk("flush_w", 32'(flush_w), 32'(mon_e.flush_w));
      chk("fwd_a_d", 32'(fwd_a_d), 32'(mon_e.fwd_a_d));
      chk("fwd_b_d", 32'(fwd_b_d), 32'(mon_e.fwd_b_d));
      chk("fwd_a_x", 32'(fwd_a_x), 32'(mon_e.fwd_a_x));
      chk("fwd_b_x", 32'(fwd_b_x), 32'(mon_e.fwd_b_x));
      chk("forward_w_m", 32'(forward_w_m), 32'(mon_e.forward_w_m));
      chk("dmem_req", 32'(dmem_req), 32'(mon_e.dmem_req));
      chk("mem_timeout", 32'(mem_timeout), 32'(mon_e.mem_timeout));
      chk("stall_count", 32'(stall_count), 32'(mon_e.stall_count));
      chk("flush_count", 32'(flush_count), 32'(mon_e.flush_count));
    end
  end

  initial begin
    idle_inputs();
    reset = 1'b0;
    // Reset state, with a pending memory op: dmem_req still follows mem_op.
    step();
    dmem_write_m = 1'b1;
    step();
    idle_inputs();
    step();

    // Load-use: lw $2 in X, add in D reads $2; then result forwarded from W.
    mem_to_reg_x = 1'b1; rt_x = 5'd2; rs_d = 5'd2;
    step();
    idle_inputs();
    mem_to_reg_m = 1'b1; write_reg_m = 5'd2; dmem_ack = 1'b1;
    rs_x = 5'd2; reg_write_w = 1'b1; write_reg_w = 5'd2;
    step();

    // M beats W; register 0 never forwards.
    idle_inputs();
    reg_write_m = 1'b1; write_reg_m = 5'd5; reg_write_w = 1'b1; write_reg_w = 5'd5; rs_x = 5'd5;
    step();
    rs_x = 5'd0; write_reg_m = 5'd0; write_reg_w = 5'd0;
    step();

    // Branch operand from ALU op in X, then D-stage forward and redirect.
    idle_inputs();
    branch_d = 1'b1; rs_d = 5'd3; reg_write_x = 1'b1; write_reg_x = 5'd3;
    step();
    reg_write_x = 1'b0; reg_write_m = 1'b1; write_reg_m = 5'd3; pc_src_d = 1'b1;
    step();

    // Store with ack after three frozen cycles.
    idle_inputs();
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0; dmem_write_m = 1'b1;
    repeat (3) step();
    dmem_ack = 1'b1;
    step();
    idle_inputs();
    step();

    // Ack never arrives: timeout release, then clear.
    dmem_write_m = 1'b1;
    repeat (6) step();
    idle_inputs();
    step();
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    step();

    // Async reset in cycle 2 of MEM_WAIT.
    mem_to_reg_m = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();

    // Continuous load-use stall drives the 4-bit counter into saturation.
    idle_inputs();
    mem_to_reg_x = 1'b1; rt_x = 5'd7; rt_d = 5'd7;
    repeat (20) step();

    // Randomized traffic over a small register space to provoke hits.
    for (int i = 0; i < 600; i++) begin
      idle_inputs();
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_x = 5'($urandom_range(0, 3)); rt_x = 5'($urandom_range(0, 3));
      rt_m = 5'($urandom_range(0, 3));
      write_reg_x = 5'($urandom_range(0, 3));
      write_reg_m = 5'($urandom_range(0, 3));
      write_reg_w = 5'($urandom_range(0, 3));
      reg_write_x = 1'($urandom_range(0, 1));
      reg_write_m = 1'($urandom_range(0, 1));
      reg_write_w = 1'($urandom_range(0, 1));
      mem_to_reg_x = ($urandom_range(0, 3) == 0);
      mem_to_reg_m = ($urandom_range(0, 3) != 0);
      dmem_write_m = ($urandom_range(0, 3) == 0);
      branch_d = 1'($urandom_range(0, 1));
      jump_d   = ($urandom_range(0, 3) == 0);
      pc_src_d = ($urandom_range(0, 3) == 0);
      dmem_ack = ($urandom_range(0, 3) == 0);
      cnt_clear = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 59) != 0);
      step();
    end

    idle_inputs();
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and stall controller for the 5-stage MIPS pipeline datapath. Computes all forwarding selects, load-use and branch-operand stalls, and control-hazard flushes. Sequences a variable-latency data memory through a req/ack handshake: it freezes the pipeline while an access is outstanding and recovers from a memory timeout. Keeps saturating stall and flush performance counters. Sits beside the controller and drives the datapath's stall/flush/forward inputs.

Parameters:
MEM_TIMEOUT, 255, max cycles in MEM_WAIT before forced release (>=1)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; all state cleared while low
rs_d, rt_d, rs_x, rt_x, rt_m  in  5 each  source register ids per stage
write_reg_x, write_reg_m, write_reg_w  in  5 each  destination ids
reg_write_x, reg_write_m, reg_write_w  in  1 each  stage writes regfile
mem_to_reg_x, mem_to_reg_m  in  1 each  load in X / M
dmem_write_m  in  1  store in M
branch_d, jump_d, pc_src_d  in  1 each  branch in D, jump in D, branch taken
dmem_ack  in  1  memory completes current access this cycle
cnt_clear  in  1  synchronous clear of counters and timeout flag
stall_f, stall_d  out  1 each  hold PC / F-D registers
stall_x, stall_m  out  1 each  hold D-X / X-M registers (memory freeze)
flush_d  out  1  clear F-D registers (redirect)
flush_x  out  1  clear D-X registers (bubble)
flush_w  out  1  clear M-W registers (bubble during freeze)
fwd_a_d, fwd_b_d  out  1 each  D-stage equality operand from alu_out_m
fwd_a_x, fwd_b_x  out  2 each  00 regfile, 01 result_w, 10 alu_out_m
forward_w_m  out  1  store data from result_w
dmem_req  out  1  memory access request
mem_timeout  out  1  sticky, set on timeout release
stall_count, flush_count  out  CNT_W each  saturating counters

Behaviour:
- Register 0 never matches any hazard or forward condition.
- fwd_a_x = 10 if reg_write_m & write_reg_m==rs_x; else 01 if reg_write_w & write_reg_w==rs_x; else 00. fwd_b_x is the same with rt_x. M beats W.
- fwd_a_d = reg_write_m & write_reg_m==rs_d; fwd_b_d uses rt_d.
- forward_w_m = dmem_write_m & reg_write_w & write_reg_w==rt_m.
- lwstall = mem_to_reg_x & (rt_x==rs_d | rt_x==rt_d).
- brstall = branch_d & ((reg_write_x & write_reg_x in {rs_d,rt_d}) | (mem_to_reg_m & write_reg_m in {rs_d,rt_d})).
- mem_op = mem_to_reg_m | dmem_write_m. dmem_req = mem_op, combinational.
- freeze = mem_op & ~dmem_ack & ~tmo_hit. tmo_hit is 1 in MEM_WAIT when wait_cnt == MEM_TIMEOUT-1.
- Zero-wait access (ack in first request cycle): no freeze.
- freeze=1: stall_f = stall_d = stall_x = stall_m = 1, flush_w = 1, flush_x = 0, flush_d = 0. Freeze overrides lwstall, brstall and redirect.
- freeze=0: stall_f = stall_d = flush_x = lwstall|brstall; stall_x = stall_m = flush_w = 0; flush_d = (pc_src_d|jump_d) & ~stall_d.
- FSM IDLE: on mem_op & ~dmem_ack, go to MEM_WAIT with wait_cnt=0.
- FSM MEM_WAIT: wait_cnt increments each cycle.
  - dmem_ack: go to IDLE.
  - tmo_hit & ~ack: set mem_timeout, go to IDLE. The access retires with undefined read data.
  - ack and tmo_hit in the same cycle: ack wins; mem_timeout is not set.
- Memory ops in back-to-back instructions: a new request is issued the cycle after the previous ack. No idle cycle is required.
- stall_count increments on cycles with stall_d=1. flush_count increments on cycles with flush_x|flush_d=1 (+1 per cycle, not per signal). Both saturate at all-ones.
- cnt_clear zeroes both counters and mem_timeout. It wins over an increment in the same cycle.
- Reset low (any time, including mid-MEM_WAIT):
  - FSM to IDLE, wait_cnt=0, counters=0, mem_timeout=0.
  - Combinational outputs follow the inputs; dmem_req is still driven from mem_op.
  - Datapath reset blocks the resulting effects.

Test Plan:
- lw $2 in X (mem_to_reg_x=1, rt_x=2), add in D using rs_d=2 -> stall_f=stall_d=flush_x=1 for one cycle; next cycle fwd_a_x=01 (write_reg_w=2).
- reg_write_m=1, write_reg_m=5 and reg_write_w=1, write_reg_w=5, rs_x=5 -> fwd_a_x=10; rs_x=0 with write_reg_m=0 -> fwd_a_x=00.
- beq in D, rs_d=3, prior ALU op in X writing 3 -> brstall for 1 cycle; then fwd_a_d=1; pc_src_d=1 -> flush_d=1.
- Store in M, dmem_ack after 3 cycles -> freeze and flush_w high for exactly 3 cycles, FSM returns to IDLE, stall_count=3.
- MEM_TIMEOUT=4, ack never arrives -> freeze for 4 cycles then released, mem_timeout=1; cnt_clear -> mem_timeout=0, counters=0.
- Reset pulled low in cycle 2 of MEM_WAIT -> state IDLE and counters 0 immediately (asynchronous); stall_count saturates at 2^CNT_W-1 under continuous stall (CNT_W=4: stays 15).
